// File: rtl/router_pkg.sv
// Shared router types: FSM state encoding and wait-timer defaults.
package router_pkg;

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        LOAD_DATA          = 4'd2,
        LOAD_PARITY        = 4'd3,
        FIFO_FULL_STATE    = 4'd4,
        LOAD_AFTER_FULL    = 4'd5,
        WAIT_TILL_EMPTY    = 4'd6,
        CHECK_PARITY_ERROR = 4'd7,
        DROP_PACKET        = 4'd8
    } router_state_t;

    localparam int WAIT_MAX_DEFAULT = 255;
    localparam int WAIT_CNT_W       = 16;

endpackage

// File: rtl/router_wait_timer.sv
// Saturating wait counter; done flags the cycle whose increment reaches MAX.
module router_wait_timer
    import router_pkg::*;
#(
    parameter int MAX = WAIT_MAX_DEFAULT
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic done
);

    logic [WAIT_CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && int'(count) < MAX) begin
            count <= count + 1'b1;
        end
    end

    assign done = (int'(count) + 1) >= MAX;

endmodule

// File: rtl/router_fsm_param.sv
// Router control FSM: header decode, load sequencing, wait timeout, drop.
module router_fsm_param
    import router_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = $clog2(NUM_PORTS),
    parameter int WAIT_MAX  = WAIT_MAX_DEFAULT
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 write_enb_reg,
    output logic                 busy,
    output logic                 drop_state,
    output logic                 timeout_err,
    output logic [NUM_PORTS-1:0] dest_sel
);

    router_state_t         state;
    router_state_t         next_state;
    logic [ADDR_W-1:0]     addr_q;
    logic [ADDR_W-1:0]     addr_n;
    logic [NUM_PORTS-1:0]  dest_n;
    logic                  in_ok;
    logic                  reg_ok;
    logic                  soft_hit;
    logic                  reg_empty;
    logic                  wait_done;
    logic                  wait_clr;
    logic                  wait_en;
    logic                  tmo_n;

    router_wait_timer #(
        .MAX (WAIT_MAX)
    ) u_wait_timer (
        .clock  (clock),
        .resetn (resetn),
        .clear  (wait_clr),
        .enable (wait_en),
        .done   (wait_done)
    );

    always_comb begin
        in_ok     = int'(data_in) < NUM_PORTS;
        reg_ok    = int'(addr_q) < NUM_PORTS;
        soft_hit  = reg_ok && soft_reset[addr_q];
        reg_empty = reg_ok && fifo_empty[addr_q];
        addr_n    = (state == DECODE_ADDRESS) ? data_in : addr_q;

        next_state = DECODE_ADDRESS;
        tmo_n      = 1'b0;
        unique case (state)
            DECODE_ADDRESS: begin
                if (!pkt_valid)
                    next_state = DECODE_ADDRESS;
                else if (!in_ok)
                    next_state = DROP_PACKET;
                else if (fifo_empty[data_in])
                    next_state = LOAD_FIRST_DATA;
                else
                    next_state = WAIT_TILL_EMPTY;
            end
            LOAD_FIRST_DATA: next_state = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)
                    next_state = FIFO_FULL_STATE;
                else if (!pkt_valid)
                    next_state = LOAD_PARITY;
                else
                    next_state = LOAD_DATA;
            end
            LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            FIFO_FULL_STATE: begin
                next_state = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)
                    next_state = DECODE_ADDRESS;
                else if (low_pkt_valid)
                    next_state = LOAD_PARITY;
                else
                    next_state = LOAD_DATA;
            end
            WAIT_TILL_EMPTY: begin
                if (reg_empty) begin
                    next_state = LOAD_FIRST_DATA;
                end else if (wait_done) begin
                    next_state = DROP_PACKET;
                    tmo_n      = 1'b1;
                end else begin
                    next_state = WAIT_TILL_EMPTY;
                end
            end
            DROP_PACKET: begin
                next_state = pkt_valid ? DROP_PACKET : DECODE_ADDRESS;
            end
            default: next_state = DECODE_ADDRESS;
        endcase

        // Soft reset of the latched port aborts whatever the packet was doing
        if (soft_hit) begin
            next_state = DECODE_ADDRESS;
            tmo_n      = 1'b0;
        end

        wait_clr = (next_state == WAIT_TILL_EMPTY) &&
                   (state != WAIT_TILL_EMPTY);
        wait_en  = (state == WAIT_TILL_EMPTY) && !reg_empty;

        dest_n = '0;
        if (int'(addr_n) < NUM_PORTS &&
            next_state != DECODE_ADDRESS &&
            next_state != DROP_PACKET)
            dest_n[addr_n] = 1'b1;
    end

    // Outputs registered from next_state so they track the present state
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state         <= DECODE_ADDRESS;
            addr_q        <= '0;
            detect_add    <= 1'b1;
            lfd_state     <= 1'b0;
            ld_state      <= 1'b0;
            laf_state     <= 1'b0;
            full_state    <= 1'b0;
            rst_int_reg   <= 1'b0;
            write_enb_reg <= 1'b0;
            busy          <= 1'b0;
            drop_state    <= 1'b0;
            timeout_err   <= 1'b0;
            dest_sel      <= '0;
        end else begin
            state         <= next_state;
            addr_q        <= addr_n;
            detect_add    <= next_state == DECODE_ADDRESS;
            lfd_state     <= next_state == LOAD_FIRST_DATA;
            ld_state      <= next_state == LOAD_DATA;
            laf_state     <= next_state == LOAD_AFTER_FULL;
            full_state    <= next_state == FIFO_FULL_STATE;
            rst_int_reg   <= next_state == CHECK_PARITY_ERROR;
            write_enb_reg <= next_state == LOAD_DATA ||
                             next_state == LOAD_AFTER_FULL ||
                             next_state == LOAD_PARITY;
            busy          <= !(next_state == DECODE_ADDRESS ||
                               next_state == LOAD_DATA ||
                               next_state == DROP_PACKET);
            drop_state    <= next_state == DROP_PACKET;
            timeout_err   <= tmo_n;
            dest_sel      <= dest_n;
        end
    end

endmodule

// File: tb/tb_router_fsm_param.sv
// Scoreboard bench for router_fsm_param: two instances (WAIT_MAX 255 and 4).
module tb_router_fsm_param;
    import router_pkg::*;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [1:0] data_in = '0;
    logic [2:0] fifo_empty = '0;
    logic       fifo_full = 1'b0;
    logic [2:0] soft_reset = '0;
    logic       parity_done = 1'b0;
    logic       low_pkt_valid = 1'b0;

    logic       da[2], lfd[2], ld[2], laf[2], fs[2];
    logic       ri[2], we[2], bz[2], dr[2], to[2];
    logic [2:0] ds[2];
    logic [12:0] ov[2];

    typedef struct {
        string       nm;
        logic [12:0] v;
        int          sel;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    router_fsm_param #(.NUM_PORTS(3), .WAIT_MAX(255)) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid),
        .data_in(data_in), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .soft_reset(soft_reset),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(da[0]), .lfd_state(lfd[0]), .ld_state(ld[0]),
        .laf_state(laf[0]), .full_state(fs[0]), .rst_int_reg(ri[0]),
        .write_enb_reg(we[0]), .busy(bz[0]), .drop_state(dr[0]),
        .timeout_err(to[0]), .dest_sel(ds[0])
    );

    router_fsm_param #(.NUM_PORTS(3), .WAIT_MAX(4)) dut4 (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid),
        .data_in(data_in), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .soft_reset(soft_reset),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(da[1]), .lfd_state(lfd[1]), .ld_state(ld[1]),
        .laf_state(laf[1]), .full_state(fs[1]), .rst_int_reg(ri[1]),
        .write_enb_reg(we[1]), .busy(bz[1]), .drop_state(dr[1]),
        .timeout_err(to[1]), .dest_sel(ds[1])
    );

    assign ov[0] = {da[0], lfd[0], ld[0], laf[0], fs[0], ri[0],
                    we[0], bz[0], dr[0], to[0], ds[0]};
    assign ov[1] = {da[1], lfd[1], ld[1], laf[1], fs[1], ri[1],
                    we[1], bz[1], dr[1], to[1], ds[1]};

    // Expected output vector for a state, straight from the decode table
    function automatic logic [12:0] ev(router_state_t s, logic [2:0] d,
                                       logic t);
        return {s == DECODE_ADDRESS, s == LOAD_FIRST_DATA,
                s == LOAD_DATA, s == LOAD_AFTER_FULL,
                s == FIFO_FULL_STATE, s == CHECK_PARITY_ERROR,
                s == LOAD_DATA || s == LOAD_AFTER_FULL ||
                s == LOAD_PARITY,
                !(s == DECODE_ADDRESS || s == LOAD_DATA ||
                  s == DROP_PACKET),
                s == DROP_PACKET, t, d};
    endfunction

    // sel: 0 = dut only, 1 = dut4 only, 2 = both
    task automatic st(input string nm, input logic rn, input logic pv,
                      input logic [1:0] din, input logic [2:0] emp,
                      input logic ff, input logic [2:0] sr,
                      input logic pd, input logic lpv,
                      input router_state_t s, input logic [2:0] d,
                      input logic t, input int sel);
        exp_t e;
        @(negedge clock);
        resetn = rn;
        pkt_valid = pv;
        data_in = din;
        fifo_empty = emp;
        fifo_full = ff;
        soft_reset = sr;
        parity_done = pd;
        low_pkt_valid = lpv;
        e.nm = nm;
        e.v = ev(s, d, t);
        e.sel = sel;
        q.push_back(e);
    endtask

    task automatic rst_both();
        st("reset", 0, 0, 0, 3'b111, 0, 0, 0, 0,
           DECODE_ADDRESS, 3'b000, 0, 2);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                for (int k = 0; k < 2; k++) begin
                    if (e.sel == 2 || e.sel == k) begin
                        total++;
                        if (ov[k] !== e.v) begin
                            bad++;
                            $display("FAIL %s dut%0d: got %b want %b",
                                     e.nm, k, ov[k], e.v);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst_both();
        st("idle", 1, 0, 0, 3'b111, 0, 0, 0, 0,
           DECODE_ADDRESS, 3'b000, 0, 2);

        // Normal packet to port 1
        st("n_lfd", 1, 1, 1, 3'b111, 0, 0, 0, 0,
           LOAD_FIRST_DATA, 3'b010, 0, 2);
        for (int i = 0; i < 4; i++)
            st("n_ld", 1, 1, 0, 3'b111, 0, 0, 0, 0,
               LOAD_DATA, 3'b010, 0, 2);
        st("n_lp", 1, 0, 0, 3'b111, 0, 0, 0, 0,
           LOAD_PARITY, 3'b010, 0, 2);
        st("n_cp", 1, 0, 0, 3'b111, 0, 0, 0, 0,
           CHECK_PARITY_ERROR, 3'b010, 0, 2);
        st("n_dec", 1, 0, 0, 3'b111, 0, 0, 0, 0,
           DECODE_ADDRESS, 3'b000, 0, 2);

        // Port 2 not empty for 10 cycles, long timeout
        for (int i = 0; i < 10; i++)
            st("w_wait", 1, 1, 2, 3'b011, 0, 0, 0, 0,
               WAIT_TILL_EMPTY, 3'b100, 0, 0);
        st("w_lfd", 1, 1, 2, 3'b111, 0, 0, 0, 0,
           LOAD_FIRST_DATA, 3'b100, 0, 0);
        st("w_ld", 1, 1, 0, 3'b111, 0, 0, 0, 0,
           LOAD_DATA, 3'b100, 0, 0);
        st("w_lp", 1, 0, 0, 3'b111, 0, 0, 0, 0,
           LOAD_PARITY, 3'b100, 0, 0);
        st("w_cp", 1, 0, 0, 3'b111, 0, 0, 0, 0,
           CHECK_PARITY_ERROR, 3'b100, 0, 0);
        st("w_dec", 1, 0, 0, 3'b111, 0, 0, 0, 0,
           DECODE_ADDRESS, 3'b000, 0, 0);

        // Timeout on port 0 with WAIT_MAX=4
        rst_both();
        for (int i = 0; i < 4; i++)
            st("t_wait", 1, 1, 0, 3'b110, 0, 0, 0, 0,
               WAIT_TILL_EMPTY, 3'b001, 0, 1);
        st("t_tmo", 1, 1, 0, 3'b110, 0, 0, 0, 0,
           DROP_PACKET, 3'b000, 1, 1);
        st("t_drop1", 1, 1, 0, 3'b110, 0, 0, 0, 0,
           DROP_PACKET, 3'b000, 0, 1);
        st("t_drop2", 1, 1, 0, 3'b110, 0, 0, 0, 0,
           DROP_PACKET, 3'b000, 0, 1);
        st("t_dec", 1, 0, 0, 3'b110, 0, 0, 0, 0,
           DECODE_ADDRESS, 3'b000, 0, 1);

        // Illegal address 3
        rst_both();
        st("x_drop", 1, 1, 3, 3'b111, 0, 0, 0, 0,
           DROP_PACKET, 3'b000, 0, 2);
        for (int i = 0; i < 2; i++)
            st("x_hold", 1, 1, 0, 3'b111, 0, 0, 0, 0,
               DROP_PACKET, 3'b000, 0, 2);
        st("x_dec", 1, 0, 0, 3'b111, 0, 0, 0, 0,
           DECODE_ADDRESS, 3'b000, 0, 2);

        // Full during load, low_pkt_valid on release
        st("f_lfd", 1, 1, 0, 3'b111, 0, 0, 0, 0,
           LOAD_FIRST_DATA, 3'b001, 0, 2);
        st("f_ld", 1, 1, 0, 3'b111, 0, 0, 0, 0,
           LOAD_DATA, 3'b001, 0, 2);
        for (int i = 0; i < 3; i++)
            st("f_full", 1, 1, 0, 3'b111, 1, 0, 0, 0,
               FIFO_FULL_STATE, 3'b001, 0, 2);
        st("f_laf", 1, 0, 0, 3'b111, 0, 0, 0, 1,
           LOAD_AFTER_FULL, 3'b001, 0, 2);
        st("f_lp", 1, 0, 0, 3'b111, 0, 0, 0, 1,
           LOAD_PARITY, 3'b001, 0, 2);
        st("f_cp", 1, 0, 0, 3'b111, 0, 0, 0, 0,
           CHECK_PARITY_ERROR, 3'b001, 0, 2);
        st("f_dec", 1, 0, 0, 3'b111, 0, 0, 0, 0,
           DECODE_ADDRESS, 3'b000, 0, 2);

        // Full then parity_done on release goes straight to decode
        st("p_lfd", 1, 1, 2, 3'b111, 0, 0, 0, 0,
           LOAD_FIRST_DATA, 3'b100, 0, 2);
        st("p_ld", 1, 1, 0, 3'b111, 0, 0, 0, 0,
           LOAD_DATA, 3'b100, 0, 2);
        st("p_full", 1, 0, 0, 3'b111, 1, 0, 0, 0,
           FIFO_FULL_STATE, 3'b100, 0, 2);
        st("p_laf", 1, 0, 0, 3'b111, 0, 0, 1, 0,
           LOAD_AFTER_FULL, 3'b100, 0, 2);
        st("p_dec", 1, 0, 0, 3'b111, 0, 0, 1, 0,
           DECODE_ADDRESS, 3'b000, 0, 2);

        // Soft reset of the selected port aborts the packet
        st("s_lfd", 1, 1, 1, 3'b111, 0, 0, 0, 0,
           LOAD_FIRST_DATA, 3'b010, 0, 2);
        st("s_ld", 1, 1, 0, 3'b111, 0, 0, 0, 0,
           LOAD_DATA, 3'b010, 0, 2);
        st("s_hit", 1, 1, 0, 3'b111, 0, 3'b010, 0, 0,
           DECODE_ADDRESS, 3'b000, 0, 2);
        st("s_idle", 1, 0, 0, 3'b111, 0, 0, 0, 0,
           DECODE_ADDRESS, 3'b000, 0, 2);

        // Soft reset of another port is ignored; hard reset mid-packet
        st("o_lfd", 1, 1, 1, 3'b111, 0, 0, 0, 0,
           LOAD_FIRST_DATA, 3'b010, 0, 2);
        st("o_ld", 1, 1, 0, 3'b111, 0, 0, 0, 0,
           LOAD_DATA, 3'b010, 0, 2);
        st("o_other", 1, 1, 0, 3'b111, 0, 3'b001, 0, 0,
           LOAD_DATA, 3'b010, 0, 2);
        st("o_ld2", 1, 1, 0, 3'b111, 0, 0, 0, 0,
           LOAD_DATA, 3'b010, 0, 2);
        st("o_hard", 0, 1, 0, 3'b111, 0, 0, 0, 0,
           DECODE_ADDRESS, 3'b000, 0, 2);
        st("o_idle", 1, 0, 0, 3'b111, 0, 0, 0, 0,
           DECODE_ADDRESS, 3'b000, 0, 2);

        for (int i = 0; i < 5 && q.size() != 0; i++)
            @(negedge clock);
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
